// File: rtl/writeback_if.sv
// Writeback-stage bundle: execute-stage result, data-memory read handshake,
// register-file write port and the stall/fault status lines.
interface writeback_if;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [1:0]  wb_sel;
  logic [4:0]  wb_rd;
  logic [31:0] wb_alu_result;
  logic [31:0] wb_pc_plus4;
  logic [31:0] wb_imm;
  logic [2:0]  wb_funct3;

  logic        mem_read_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        register_write_en;
  logic [4:0]  rd_address;
  logic [31:0] register_write_data;

  logic        stall;
  logic        load_fault;

  // Upstream pipeline plus data memory; drives results and memory responses.
  modport master (
    output wb_valid, wb_reg_write, wb_sel, wb_rd, wb_alu_result, wb_pc_plus4,
           wb_imm, wb_funct3, mem_ack, mem_rdata,
    input  mem_read_req, mem_addr, register_write_en, rd_address,
           register_write_data, stall, load_fault
  );

  modport slave (
    input  wb_valid, wb_reg_write, wb_sel, wb_rd, wb_alu_result, wb_pc_plus4,
           wb_imm, wb_funct3, mem_ack, mem_rdata,
    output mem_read_req, mem_addr, register_write_en, rd_address,
           register_write_data, stall, load_fault
  );
endinterface

// File: rtl/writeback_unit.sv
// RV32I writeback stage: selects the result, performs loads through a
// single-outstanding memory read with a 256-cycle timeout, writes the register file.
module writeback_unit (
  input  logic       clk,
  input  logic       rst,
  writeback_if.slave bus
);

  typedef enum logic {IDLE, LOAD_WAIT} state_t;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;
  localparam logic [1:0] SEL_IMM  = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [7:0] WAIT_LAST = 8'hFF;

  state_t      state, state_next;
  logic [7:0]  wait_count, wait_count_next;

  // Context of the load in flight, captured at accept time so that the
  // upstream values are free to change while we wait.
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_offset;
  logic [4:0]  ld_rd;
  logic        ld_write;
  logic [31:0] addr_q;
  logic        capture;

  logic        we_q, we_next;
  logic [4:0]  rd_q, rd_next;
  logic [31:0] data_q, data_next;
  logic        fault_q, fault_next;

  function automatic logic load_illegal(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_LB, F3_LBU: return 1'b0;
      F3_LH, F3_LHU: return off[0];
      F3_LW:         return off != 2'b00;
      default:       return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] extract_load(input logic [2:0]  f3,
                                               input logic [1:0]  off,
                                               input logic [31:0] word);
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    byte_val = word[{off, 3'b000} +: 8];
    half_val = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_LB:   return {{24{byte_val[7]}}, byte_val};
      F3_LH:   return {{16{half_val[15]}}, half_val};
      F3_LBU:  return {24'd0, byte_val};
      F3_LHU:  return {16'd0, half_val};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] select_result(input logic [1:0]  sel,
                                                input logic [31:0] alu,
                                                input logic [31:0] pc4,
                                                input logic [31:0] imm);
    case (sel)
      SEL_ALU: return alu;
      SEL_PC4: return pc4;
      SEL_IMM: return imm;
      default: return 32'd0;
    endcase
  endfunction

  // NOTE: every variable gets a default before the case, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_next      = state;
    wait_count_next = wait_count;
    we_next         = 1'b0;
    rd_next         = rd_q;
    data_next       = data_q;
    fault_next      = 1'b0;
    capture         = 1'b0;

    case (state)
      IDLE: begin
        if (bus.wb_valid) begin
          if (bus.wb_sel == SEL_LOAD) begin
            if (load_illegal(bus.wb_funct3, bus.wb_alu_result[1:0])) begin
              fault_next = 1'b1;
            end else begin
              state_next      = LOAD_WAIT;
              wait_count_next = 8'd0;
              capture         = 1'b1;
            end
          end else begin
            we_next   = bus.wb_reg_write && (bus.wb_rd != 5'd0);
            rd_next   = bus.wb_rd;
            data_next = select_result(bus.wb_sel, bus.wb_alu_result,
                                      bus.wb_pc_plus4, bus.wb_imm);
          end
        end
      end

      LOAD_WAIT: begin
        // An ack on the final wait cycle still completes the load.
        if (bus.mem_ack) begin
          state_next = IDLE;
          we_next    = ld_write && (ld_rd != 5'd0);
          rd_next    = ld_rd;
          data_next  = extract_load(ld_funct3, ld_offset, bus.mem_rdata);
        end else if (wait_count == WAIT_LAST) begin
          state_next = IDLE;
          fault_next = 1'b1;
        end else begin
          wait_count_next = wait_count + 8'd1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wait_count <= 8'd0;
    end else begin
      state      <= state_next;
      wait_count <= wait_count_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_funct3 <= 3'd0;
      ld_offset <= 2'd0;
      ld_rd     <= 5'd0;
      ld_write  <= 1'b0;
      addr_q    <= 32'd0;
    end else if (capture) begin
      ld_funct3 <= bus.wb_funct3;
      ld_offset <= bus.wb_alu_result[1:0];
      ld_rd     <= bus.wb_rd;
      ld_write  <= bus.wb_reg_write;
      addr_q    <= {bus.wb_alu_result[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      rd_q    <= 5'd0;
      data_q  <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      we_q    <= we_next;
      rd_q    <= rd_next;
      data_q  <= data_next;
      fault_q <= fault_next;
    end
  end

  assign bus.stall               = (state == LOAD_WAIT);
  assign bus.mem_read_req        = (state == LOAD_WAIT);
  assign bus.mem_addr            = addr_q;
  assign bus.register_write_en   = we_q;
  assign bus.rd_address          = rd_q;
  assign bus.register_write_data = data_q;
  assign bus.load_fault          = fault_q;

  no_write_to_x0: assert property (@(posedge clk) disable iff (!rst)
    bus.register_write_en |-> (bus.rd_address != 5'd0));

  no_write_with_fault: assert property (@(posedge clk) disable iff (!rst)
    !(bus.register_write_en && bus.load_fault));

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus randomized
// instruction streams checked against a transaction-level reference model.
module tb_writeback_unit;

  logic clk;
  logic rst;

  writeback_if bus();

  writeback_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic        is_load;
    logic        fault;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] addr;
  } expect_t;

  // Outcome of one instruction, derived directly from the RV32I load rules.
  function automatic expect_t model(input logic        reg_write,
                                    input logic [1:0]  sel,
                                    input logic [4:0]  rd,
                                    input logic [2:0]  f3,
                                    input logic [31:0] alu,
                                    input logic [31:0] pc4,
                                    input logic [31:0] imm,
                                    input logic [31:0] rdata);
    expect_t     e;
    int          off;
    logic [31:0] sh;
    e         = '0;
    e.rd      = rd;
    off       = int'(alu % 32'd4);
    e.addr    = alu - 32'(off);
    e.is_load = (sel == 2'b01);
    if (!e.is_load) begin
      if (sel == 2'b00)      e.data = alu;
      else if (sel == 2'b10) e.data = pc4;
      else                   e.data = imm;
      e.we = reg_write && (rd != 5'd0);
    end else begin
      case (f3)
        3'd0, 3'd4: e.fault = 1'b0;
        3'd1, 3'd5: e.fault = (off % 2) != 0;
        3'd2:       e.fault = (off != 0);
        default:    e.fault = 1'b1;
      endcase
      sh = rdata >> (8 * off);
      case (f3)
        3'd0:    e.data = 32'($signed(sh[7:0]));
        3'd1:    e.data = 32'($signed(sh[15:0]));
        3'd4:    e.data = {24'd0, sh[7:0]};
        3'd5:    e.data = {16'd0, sh[15:0]};
        default: e.data = rdata;
      endcase
      e.we = !e.fault && reg_write && (rd != 5'd0);
    end
    return e;
  endfunction

  task automatic drive(input logic v, input logic rw, input logic [1:0] sel,
                       input logic [4:0] rd, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] pc4,
                       input logic [31:0] imm);
    bus.wb_valid      = v;
    bus.wb_reg_write  = rw;
    bus.wb_sel        = sel;
    bus.wb_rd         = rd;
    bus.wb_funct3     = f3;
    bus.wb_alu_result = alu;
    bus.wb_pc_plus4   = pc4;
    bus.wb_imm        = imm;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction for one cycle and checks everything it causes.
  // ack_delay counts LOAD_WAIT cycles including the ack cycle; 0 means never ack.
  task automatic run_instr(input string tag, input logic rw, input logic [1:0] sel,
                           input logic [4:0] rd, input logic [2:0] f3,
                           input logic [31:0] alu, input logic [31:0] pc4,
                           input logic [31:0] imm, input int ack_delay,
                           input logic [31:0] rdata, input bit garbage);
    expect_t    e;
    logic [3:0] obs;
    logic [3:0] want;
    int         waits;
    e = model(rw, sel, rd, f3, alu, pc4, imm, rdata);
    drive(1'b1, rw, sel, rd, f3, alu, pc4, imm);
    next_cycle();

    if (e.is_load && !e.fault) begin
      waits = (ack_delay == 0) ? 256 : ack_delay;
      for (int i = 0; i < waits; i++) begin
        compared++;
        if ({bus.stall, bus.mem_read_req, bus.register_write_en, bus.load_fault,
             bus.mem_addr} !== {4'b1100, e.addr}) begin
          mismatched++;
          $display("FAIL %s wait[%0d]: got flags=%b addr=%h want flags=1100 addr=%h",
                   tag, i, {bus.stall, bus.mem_read_req, bus.register_write_en,
                   bus.load_fault}, bus.mem_addr, e.addr);
        end
        bus.mem_ack   = (ack_delay != 0) && (i == ack_delay - 1);
        bus.mem_rdata = bus.mem_ack ? rdata : $urandom;
        if (garbage)
          drive(1'($urandom_range(0, 1)), 1'($urandom), 2'($urandom), 5'($urandom),
                3'($urandom), $urandom, $urandom, $urandom);
        else
          bus.wb_valid = 1'b0;
        next_cycle();
      end
      bus.mem_ack = 1'b0;
      bus.wb_valid = 1'b0;
    end

    obs  = {bus.stall, bus.mem_read_req, bus.register_write_en, bus.load_fault};
    want = (e.is_load && !e.fault && ack_delay == 0) ? 4'b0001 : {2'b00, e.we, e.fault};
    compared++;
    if (obs !== want) begin
      mismatched++;
      $display("FAIL %s result flags (stall,req,we,fault): got %b want %b", tag, obs, want);
    end
    if (want[1]) begin
      compared++;
      if ({bus.rd_address, bus.register_write_data} !== {e.rd, e.data}) begin
        mismatched++;
        $display("FAIL %s write: got rd=%0d data=%h want rd=%0d data=%h",
                 tag, bus.rd_address, bus.register_write_data, e.rd, e.data);
      end
    end
  endtask

  // One cycle with no valid instruction: every pulse must have ended.
  task automatic idle_check(input string tag, input logic ack);
    bus.wb_valid = 1'b0;
    bus.mem_ack  = ack;
    next_cycle();
    bus.mem_ack  = 1'b0;
    compared++;
    if ({bus.stall, bus.mem_read_req, bus.register_write_en, bus.load_fault} !== 4'b0000) begin
      mismatched++;
      $display("FAIL %s idle flags: got %b want 0000", tag,
               {bus.stall, bus.mem_read_req, bus.register_write_en, bus.load_fault});
    end
  endtask

  task automatic check_all_zero(input string tag);
    compared++;
    if ({bus.stall, bus.mem_read_req, bus.register_write_en, bus.load_fault,
         bus.rd_address, bus.register_write_data, bus.mem_addr} !== 73'd0) begin
      mismatched++;
      $display("FAIL %s outputs: got flags=%b rd=%0d data=%h addr=%h want all zero", tag,
               {bus.stall, bus.mem_read_req, bus.register_write_en, bus.load_fault},
               bus.rd_address, bus.register_write_data, bus.mem_addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    idle_check("reset_release", 1'b0);
  endtask

  task automatic test_alu();
    run_instr("alu_rd5", 1'b1, 2'b00, 5'd5, 3'd0, 32'h1234_5678, $urandom, $urandom, 1, 32'd0, 1'b0);
    idle_check("alu_end", 1'b0);
    run_instr("imm_rd7", 1'b1, 2'b11, 5'd7, 3'd0, $urandom, $urandom, 32'hCAFE_F00D, 1, 32'd0, 1'b0);
    run_instr("no_regwrite", 1'b0, 2'b00, 5'd8, 3'd0, $urandom, $urandom, $urandom, 1, 32'd0, 1'b0);
    idle_check("imm_end", 1'b0);
  endtask

  task automatic test_lb();
    run_instr("lb_off3", 1'b1, 2'b01, 5'd10, 3'b000, 32'h0000_1003, $urandom, $urandom,
              3, 32'h80FF_0000, 1'b0);
    idle_check("lb_end", 1'b0);
  endtask

  task automatic test_lhu_misaligned();
    run_instr("lhu_off2", 1'b1, 2'b01, 5'd11, 3'b101, 32'h0000_2002, $urandom, $urandom,
              1, 32'hBEEF_1234, 1'b0);
    idle_check("lhu_end", 1'b0);
    run_instr("lw_off1", 1'b1, 2'b01, 5'd12, 3'b010, 32'h0000_3001, $urandom, $urandom,
              1, 32'd0, 1'b0);
    idle_check("lw_off1_end", 1'b0);
    run_instr("f3_is_3", 1'b1, 2'b01, 5'd13, 3'b011, 32'h0000_3000, $urandom, $urandom,
              1, 32'd0, 1'b0);
    idle_check("f3_end", 1'b0);
  endtask

  task automatic test_rd0_back_to_back();
    run_instr("pc4_rd0", 1'b1, 2'b10, 5'd0, 3'd0, $urandom, 32'h0000_0104, $urandom, 1, 32'd0, 1'b0);
    for (int r = 1; r <= 3; r++)
      run_instr($sformatf("b2b_rd%0d", r), 1'b1, 2'b00, 5'(r), 3'd0, 32'(r * 32'h1111_0000),
                $urandom, $urandom, 1, 32'd0, 1'b0);
    idle_check("b2b_end", 1'b0);
  endtask

  task automatic test_timeout();
    run_instr("lw_timeout", 1'b1, 2'b01, 5'd14, 3'b010, 32'h0000_5000, $urandom, $urandom,
              0, 32'd0, 1'b0);
    idle_check("timeout_end", 1'b0);
    idle_check("stray_ack", 1'b1);
    idle_check("stray_ack_after", 1'b0);
  endtask

  task automatic test_reset_mid_load();
    run_instr("pre_alu", 1'b1, 2'b00, 5'd9, 3'd0, 32'h0BAD_BEEF, $urandom, $urandom, 1, 32'd0, 1'b0);
    drive(1'b1, 1'b1, 2'b01, 5'd15, 3'b010, 32'h0000_4000, $urandom, $urandom);
    next_cycle();
    bus.wb_valid = 1'b0;
    next_cycle();
    compared++;
    if ({bus.stall, bus.mem_read_req, bus.mem_addr} !== {2'b11, 32'h0000_4000}) begin
      mismatched++;
      $display("FAIL rst_mid_pre: got stall=%b req=%b addr=%h want 1 1 00004000",
               bus.stall, bus.mem_read_req, bus.mem_addr);
    end
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("rst_mid_async");
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1357_9BDF;
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b1, 2'b00, 5'd21, 3'd0, 32'h0000_00A5, $urandom, $urandom);
    next_cycle();
    bus.wb_valid = 1'b0;
    bus.mem_ack  = 1'b0;
    compared++;
    if ({bus.stall, bus.mem_read_req, bus.register_write_en, bus.load_fault,
         bus.rd_address, bus.register_write_data} !== {4'b0010, 5'd21, 32'h0000_00A5}) begin
      mismatched++;
      $display("FAIL rst_first_accept: got flags=%b rd=%0d data=%h want 0010 rd=21 data=000000a5",
               {bus.stall, bus.mem_read_req, bus.register_write_en, bus.load_fault},
               bus.rd_address, bus.register_write_data);
    end
    idle_check("rst_mid_end", 1'b0);
  endtask

  task automatic test_random();
    logic [1:0] sel;
    logic [4:0] rd;
    for (int n = 0; n < 80; n++) begin
      sel = ($urandom_range(0, 9) < 4) ? 2'b01 : 2'($urandom);
      rd  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      run_instr($sformatf("rand%0d", n), 1'($urandom), sel, rd, 3'($urandom),
                $urandom, $urandom, $urandom, $urandom_range(1, 5), $urandom, 1'b1);
      if ($urandom_range(0, 2) == 0)
        idle_check($sformatf("rand%0d_idle", n), 1'($urandom));
    end
    idle_check("rand_end", 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_alu();
    test_lb();
    test_lhu_misaligned();
    test_rd0_back_to_back();
    test_timeout();
    test_reset_mid_load();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port wb_valid  input  1  execute-stage result valid this cycle.
REQ-004 SHALL have port wb_reg_write  input  1  instruction writes rd.
REQ-005 SHALL have port wb_sel  input  2  result source: 00 ALU, 01 load, 10 PC+4, 11 immediate.
REQ-006 SHALL have port wb_rd  input  5  destination register index.
REQ-007 SHALL have ports wb_alu_result, wb_pc_plus4, wb_imm  input  32 each  candidate results; wb_alu_result is also the load address.
REQ-008 SHALL have port wb_funct3  input  3  load width/sign code (RV32I encoding).
REQ-009 SHALL have ports mem_read_req (output 1), mem_addr (output 32, word-aligned), mem_ack (input 1), mem_rdata (input 32)  data-memory read handshake.
REQ-010 SHALL have ports register_write_en (output 1), rd_address (output 5), register_write_data (output 32)  register-file write port.
REQ-011 SHALL have ports stall (output 1) and load_fault (output 1)  upstream hold and one-cycle fault pulse.

Function
REQ-012 SHALL implement FSM states IDLE and LOAD_WAIT; stall = (state == LOAD_WAIT), combinational from state.
REQ-013 SHALL accept an instruction only when wb_valid=1 in IDLE; inputs in LOAD_WAIT are ignored (upstream holds them).
REQ-014 Non-load accept in cycle N with wb_reg_write=1 SHALL drive register_write_en=1 for exactly cycle N+1, with rd_address=wb_rd and data selected per wb_sel, all registered.
REQ-015 register_write_en SHALL remain 0 whenever rd is 0, wb_reg_write=0, or a fault occurs.
REQ-016 Load accept (wb_sel=01) in cycle N SHALL enter LOAD_WAIT at N+1 and assert mem_read_req from N+1 until the cycle mem_ack is sampled high, mem_addr = {wb_alu_result[31:2],2'b00} held stable.
REQ-017 mem_ack sampled high in cycle M SHALL capture mem_rdata, return to IDLE at M+1, drop mem_read_req and stall at M+1, and write the extracted value at M+1.
REQ-018 Load extraction SHALL use byte offset = wb_alu_result[1:0]: LB/LBU select byte offset, LH/LHU select halfword offset[1], LW whole word; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-019 Misalignment (LH/LHU with offset[0]=1, LW with offset!=0) or funct3 in {3,6,7} SHALL pulse load_fault in N+1, issue no memory request, no write, and stay IDLE.
REQ-020 SHALL count LOAD_WAIT cycles in an 8-bit counter; on the 256th cycle without mem_ack, SHALL pulse load_fault, drop mem_read_req, return to IDLE, and write nothing.
REQ-021 mem_ack outside LOAD_WAIT SHALL be ignored.
REQ-022 The IDLE cycle that completes a write (M+1) SHALL also accept a new instruction; back-to-back non-load accepts SHALL produce one write per cycle.

Reset
REQ-023 rst=0 SHALL immediately force state IDLE, counter 0, and all outputs 0 (stall, mem_read_req, mem_addr, register_write_en, rd_address, register_write_data, load_fault).
REQ-024 Reset during LOAD_WAIT SHALL abandon the load with no register write; first accept possible on the first rising edge after rst returns high.

Verification
REQ-025 ALU op: wb_sel=00, rd=5, alu=0x1234_5678 accepted cycle N -> write_en=1, rd=5, data=0x12345678 in N+1 only, stall never high.
REQ-026 LB: alu=0x0000_1003, funct3=000, mem_ack after 3 wait cycles with rdata=0x80FF_0000 -> mem_addr=0x1000, stall high 3 cycles, write data=0xFFFF_FF80 one cycle after ack.
REQ-027 LHU: offset 2, rdata=0xBEEF_1234 -> data=0x0000_BEEF; LW offset 1 -> load_fault pulse, no mem_read_req, no write.
REQ-028 rd=0 with PC+4 select -> register_write_en stays 0; back-to-back ALU ops rd=1,2,3 -> three consecutive write cycles.
REQ-029 Load with mem_ack never asserted -> mem_read_req for 256 cycles then load_fault pulse, IDLE, no write.
REQ-030 rst low mid-LOAD_WAIT then late mem_ack -> all outputs 0 asynchronously, ack ignored, no write.
